vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001 Parameter H_DISPLAY, default 640: active pixels per line.
- REQ-002 Parameters H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal blanking segment lengths, in pixels.
- REQ-003 Parameter V_DISPLAY, default 480: active lines per frame.
- REQ-004 Parameters V_FRONT 10, V_SYNC 2, V_BACK 33: vertical blanking segment lengths, in lines.
- REQ-005 Parameter CLK_DIV, default 4: i_clk cycles per pixel; legal range 1..16.
- REQ-006 Parameter HSYNC_POL, default 0: asserted level of o_hsync (0 = active-low).
- REQ-007 Parameter VSYNC_POL, default 0: asserted level of o_vsync.
- REQ-008 Parameter CNT_W, default 10: width of the counters and coordinates.
- REQ-009 i_clk, input, 1: sole clock.
- REQ-010 reset_n, input, 1: asynchronous active-low reset.
- REQ-011 i_enable, input, 1: run/freeze control.
- REQ-012 o_pTick, output, 1: one-i_clk-cycle pixel strobe.
- REQ-013 o_hsync and o_vsync, outputs, 1 each: sync pulses.
- REQ-014 o_displayOn, output, 1: active video region.
- REQ-015 o_x and o_y, outputs, CNT_W each: pixel coordinates.
- REQ-016 o_lineStart and o_frameStart, outputs, 1 each: event strobes.

Function
- REQ-017 H_TOTAL SHALL equal the sum of the four H parameters; V_TOTAL SHALL equal the sum of the four V parameters.
- REQ-018 Divider counter SHALL count 0..CLK_DIV-1 while i_enable=1, and o_pTick SHALL be 1 exactly when the count equals CLK_DIV-1.
- REQ-019 When CLK_DIV=1, o_pTick SHALL equal i_enable.
- REQ-020 On each o_pTick, hcnt SHALL increment and wrap from H_TOTAL-1 to 0.
- REQ-021 vcnt SHALL increment on the hcnt wrap and wrap from V_TOTAL-1 to 0 in the same cycle; it SHALL never reach V_TOTAL.
- REQ-022 Line ordering: display [0, H_DISPLAY), then front porch, then sync [H_DISPLAY+H_FRONT, +H_SYNC), then back porch; vertical ordering is identical.
- REQ-023 o_hsync SHALL equal HSYNC_POL inside the sync window and its inverse elsewhere; o_vsync likewise with VSYNC_POL.
- REQ-024 o_displayOn SHALL be 1 iff hcnt<H_DISPLAY and vcnt<V_DISPLAY.
- REQ-025 o_x and o_y SHALL equal hcnt and vcnt while o_displayOn=1, and SHALL be 0 otherwise.
- REQ-026 o_lineStart SHALL pulse for one i_clk cycle with the o_pTick on which hcnt wraps to 0.
- REQ-027 o_frameStart SHALL pulse with the o_pTick on which both hcnt and vcnt wrap to 0.
- REQ-028 When i_enable=0, the divider and counters SHALL hold, o_pTick, o_lineStart and o_frameStart SHALL be 0, and the other outputs SHALL hold their values.
- REQ-029 Counter arithmetic SHALL be CNT_W bits; a configuration with H_TOTAL or V_TOTAL >= 2^CNT_W is illegal and SHALL fail elaboration.

Reset
- REQ-030 Asserting reset_n low SHALL, without waiting for a clock edge, clear the divider, hcnt and vcnt to 0 and deassert o_pTick, o_lineStart and o_frameStart.
- REQ-031 During reset, o_displayOn SHALL be 1, o_x and o_y SHALL be 0, and syncs SHALL be at their deasserted levels.
- REQ-032 The first o_pTick after reset_n rises SHALL occur CLK_DIV enabled cycles later.
- REQ-033 Reset asserted mid-frame SHALL restart timing at pixel (0,0) with no partial pulse retained.

Configuration
- REQ-034 With macro VGA_TIMING_REGOUT_EN defined, o_hsync, o_vsync, o_displayOn, o_x, o_y, o_lineStart and o_frameStart SHALL be registered and updated on o_pTick, lagging the counters by exactly one pixel; o_pTick SHALL be unchanged.
- REQ-035 Without VGA_TIMING_REGOUT_EN, those outputs SHALL be decoded combinationally from the counters with zero latency.

Verification
- REQ-036 Defaults, i_enable=1, 1,680,000 i_clk cycles: exactly one o_frameStart, 525 o_lineStart, 420,000 o_pTick.
- REQ-037 Defaults: o_hsync=0 exactly for hcnt 656..751, o_vsync=0 exactly for vcnt 490..491, o_displayOn=1 for 307,200 pixels per frame.
- REQ-038 H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HSYNC_POL=1: o_hsync=1 at hcnt 5..6, vcnt wraps 5->0, o_x sequence 0,1,2,3,0,0,0,0.
- REQ-039 i_enable=0 for 37 cycles mid-line: counters frozen, no strobes; after release, the sequence resumes at the next pixel and the frame length grows by 37 cycles.
- REQ-040 reset_n pulsed low for a fraction of a cycle at pixel (300,200): counters read 0 immediately; the first o_pTick follows CLK_DIV cycles after release.
- REQ-041 REGOUT_EN build versus plain build: every decoded output is identical but shifted by one o_pTick, checked across a full frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel strobe from a clock divider, h/v counters, sync/blank decode.
// Build option VGA_TIMING_REGOUT_EN registers the decoded outputs one pixel behind the counters.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic             i_enable,
  output logic             o_pTick,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_displayOn,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_lineStart,
  output logic             o_frameStart
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int DIV_W    = 5;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end
  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_cnt
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP   = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP   = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(HS_START + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(VS_START + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             tick, h_wrap, v_wrap;

  // Gated by reset_n so no strobe escapes while reset is held, even with CLK_DIV=1.
  assign tick   = reset_n & i_enable & (div_q == DIV_LAST);
  assign h_wrap = (hcnt_q == H_LAST);
  assign v_wrap = (vcnt_q == V_LAST);

  // NOTE: every combinational output gets its default first, so no path infers a latch.
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (i_enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously on reset_n.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  logic             dec_disp, dec_hsync, dec_vsync;
  logic [CNT_W-1:0] dec_x, dec_y;

  assign dec_disp  = (hcnt_q < H_DISP) && (vcnt_q < V_DISP);
  assign dec_hsync = (hcnt_q >= HS_LO && hcnt_q < HS_HI) ? HSYNC_POL : ~HSYNC_POL;
  assign dec_vsync = (vcnt_q >= VS_LO && vcnt_q < VS_HI) ? VSYNC_POL : ~VSYNC_POL;
  assign dec_x     = dec_disp ? hcnt_q : '0;
  assign dec_y     = dec_disp ? vcnt_q : '0;
  assign o_pTick   = tick;

`ifdef VGA_TIMING_REGOUT_EN
  logic             hsync_q, vsync_q, disp_q, line_pend_q, frame_pend_q;
  logic [CNT_W-1:0] x_q, y_q;

  // Strobes are remembered per pixel and re-emitted on the next tick to keep them one cycle wide.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q      <= ~HSYNC_POL;
      vsync_q      <= ~VSYNC_POL;
      disp_q       <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      line_pend_q  <= 1'b0;
      frame_pend_q <= 1'b0;
    end else if (tick) begin
      hsync_q      <= dec_hsync;
      vsync_q      <= dec_vsync;
      disp_q       <= dec_disp;
      x_q          <= dec_x;
      y_q          <= dec_y;
      line_pend_q  <= h_wrap;
      frame_pend_q <= h_wrap & v_wrap;
    end
  end

  assign o_hsync      = hsync_q;
  assign o_vsync      = vsync_q;
  assign o_displayOn  = disp_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_lineStart  = tick & line_pend_q;
  assign o_frameStart = tick & frame_pend_q;
`else
  assign o_hsync      = dec_hsync;
  assign o_vsync      = dec_vsync;
  assign o_displayOn  = dec_disp;
  assign o_x          = dec_x;
  assign o_y          = dec_y;
  assign o_lineStart  = tick & h_wrap;
  assign o_frameStart = tick & h_wrap & v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster; the reference derives every output
// from the count of enabled cycles since reset using plain division and range tests.
module tb_vga_timing_gen;

  localparam int H_D = 6, H_F = 2, H_S = 3, H_B = 2;
  localparam int V_D = 4, V_F = 1, V_S = 2, V_B = 2;
  localparam int DIV = 3;
  localparam int CW  = 5;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int H_T = H_D + H_F + H_S + H_B;
  localparam int V_T = V_D + V_F + V_S + V_B;
  localparam int FRAME = H_T * V_T;
`ifdef VGA_TIMING_REGOUT_EN
  localparam bit LAG = 1'b1;
`else
  localparam bit LAG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          o_pTick, o_hsync, o_vsync, o_displayOn, o_lineStart, o_frameStart;
  logic [CW-1:0] o_x, o_y;

  int checks = 0;
  int errors = 0;
  int e = 0;
  int cyc = 0;
  int n_tick = 0, n_line = 0, n_frame = 0, n_disp = 0;

  vga_timing_gen #(
    .H_DISPLAY(H_D), .H_FRONT(H_F), .H_SYNC(H_S), .H_BACK(H_B),
    .V_DISPLAY(V_D), .V_FRONT(V_F), .V_SYNC(V_S), .V_BACK(V_B),
    .CLK_DIV(DIV), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .reset_n(reset_n), .i_enable(i_enable),
    .o_pTick(o_pTick), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_displayOn(o_displayOn), .o_x(o_x), .o_y(o_y),
    .o_lineStart(o_lineStart), .o_frameStart(o_frameStart)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  // Expected outputs for the current cycle; the registered build shows the previous pixel.
  task automatic check_model(input bit in_reset);
    int px, h, v, q, ph, pv;
    bit tick, pend;
    int disp, hs, vs, x, y, line, frame;
    tick = !in_reset && i_enable && (e % DIV == DIV - 1);
    px = (e / DIV) % FRAME;
    h  = px % H_T;
    v  = px / H_T;
    ph = h;
    pv = v;
    pend = 1'b1;
    if (LAG) begin
      if (e / DIV == 0) begin
        ph = 0; pv = 0; pend = 1'b0;
      end else begin
        q  = (e / DIV - 1) % FRAME;
        ph = q % H_T;
        pv = q / H_T;
      end
    end
    disp  = (ph < H_D && pv < V_D) ? 1 : 0;
    hs    = (ph >= H_D + H_F && ph < H_D + H_F + H_S) ? int'(HPOL) : int'(!HPOL);
    vs    = (pv >= V_D + V_F && pv < V_D + V_F + V_S) ? int'(VPOL) : int'(!VPOL);
    x     = disp ? ph : 0;
    y     = disp ? pv : 0;
    line  = (tick && pend && ph == H_T - 1) ? 1 : 0;
    frame = (line == 1 && pv == V_T - 1) ? 1 : 0;
    check("pTick",      32'(o_pTick),      32'(tick));
    check("hsync",      32'(o_hsync),      32'(hs));
    check("vsync",      32'(o_vsync),      32'(vs));
    check("displayOn",  32'(o_displayOn),  32'(disp));
    check("x",          32'(o_x),          32'(x));
    check("y",          32'(o_y),          32'(y));
    check("lineStart",  32'(o_lineStart),  32'(line));
    check("frameStart", 32'(o_frameStart), 32'(frame));
  endtask

  task automatic step(input logic en);
    @(negedge clk);
    i_enable = en;
    #1;
    check_model(1'b0);
    n_tick  += int'(o_pTick);
    n_line  += int'(o_lineStart);
    n_frame += int'(o_frameStart);
    n_disp  += int'(o_pTick && o_displayOn);
    if (en) e++;
    cyc++;
  endtask

  // Short asynchronous reset pulse inside one low clock phase; the release cycle runs enabled.
  task automatic reset_pulse();
    @(negedge clk);
    i_enable = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    e = 0;
    check_model(1'b1);
    reset_n = 1'b1;
    e = 1;
    cyc++;
  endtask

  initial begin
    int  n, t0, t1;
    bit  found;

    // Held in reset: outputs at idle values regardless of enable.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_enable = i[0];
      #1;
      check_model(1'b1);
    end
    reset_pulse();

    // Randomised enable over a few frames.
    for (int i = 0; i < 900; i++) step(logic'($urandom_range(0, 3) != 0));

    // Frame length grows by exactly the frozen cycles.
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME * DIV && !found; i++) begin
      step(1'b1);
      if (o_frameStart) found = 1'b1;
    end
    check("frame_start_seen", 32'(found), 32'd1);
    t0 = cyc;
    for (int i = 0; i < 5 * DIV + 1; i++) step(1'b1);
    for (int i = 0; i < 37; i++) step(1'b0);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME * DIV + 100 && !found; i++) begin
      step(1'b1);
      if (o_frameStart) found = 1'b1;
    end
    t1 = cyc;
    check("frame_len_with_freeze", 32'(t1 - t0), 32'(FRAME * DIV + 37));

    // Mid-frame reset at pixel (4,2), half-way through the pixel.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME * DIV && !found; i++) begin
      if ((e / DIV) % FRAME == 2 * H_T + 4 && e % DIV == 1) found = 1'b1;
      else step(1'b1);
    end
    check("reached_4_2", 32'(found), 32'd1);
    reset_pulse();
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 4 * DIV && !found; i++) begin
      step(1'b1);
      n++;
      if (o_pTick) found = 1'b1;
    end
    check("first_tick_edges", 32'(n + 1), 32'(DIV));

    // One full frame of enabled cycles: strobe and display counts.
    n_tick = 0; n_line = 0; n_frame = 0; n_disp = 0;
    for (int i = 0; i < FRAME * DIV; i++) step(1'b1);
    check("ticks_per_frame",  32'(n_tick),  32'(FRAME));
    check("lines_per_frame",  32'(n_line),  32'(V_T));
    check("frames_per_frame", 32'(n_frame), 32'd1);
    check("disp_pixels",      32'(n_disp),  32'(H_D * V_D));

    // More random enable after the directed section.
    for (int i = 0; i < 500; i++) step(logic'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
